// File: rtl/booth_pkg.sv
// Shared types and helpers for the booth sequential multiplier.
// Define BOOTH_RADIX4_EN to select radix-4 (modified Booth) recoding.
package booth_pkg;

   localparam int unsigned DefaultWidth = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      PM   = 3'd1,
      NM   = 3'd2,
      P2M  = 3'd3,
      N2M  = 3'd4
   } digit_t;

   // Radix-4 needs one extra guard bit so that +-2M never overflows the accumulator.
   function automatic int unsigned acc_width(input int unsigned n);
`ifdef BOOTH_RADIX4_EN
      return n + 2;
`else
      return n + 1;
`endif
   endfunction

   function automatic int unsigned step_count(input int unsigned n);
`ifdef BOOTH_RADIX4_EN
      return n / 2;
`else
      return n;
`endif
   endfunction

   function automatic digit_t booth_digit(input logic [2:0] bits);
      digit_t d;
      unique case (bits)
         3'b001, 3'b010: d = PM;
         3'b011:         d = P2M;
         3'b100:         d = N2M;
         3'b101, 3'b110: d = NM;
         default:        d = ZERO;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: add/sub of the multiplicand, then arithmetic shift.
// Radix-2 by default; BOOTH_RADIX4_EN selects a two-bit radix-4 step.
import booth_pkg::*;

module booth_step #(
   parameter int unsigned N = DefaultWidth
) (
   input  logic [acc_width(N)-1:0] acc,
   input  logic [N-1:0]            q,
   input  logic                    q_1,
   input  logic [acc_width(N)-1:0] m,
   output logic [acc_width(N)-1:0] acc_next,
   output logic [N-1:0]            q_next,
   output logic                    q_1_next
);

   localparam int unsigned AW = acc_width(N);

   logic [AW-1:0] sum;

`ifdef BOOTH_RADIX4_EN
   digit_t        digit;
   logic [AW-1:0] m2;

   always_comb begin
      m2    = {m[AW-2:0], 1'b0};
      digit = booth_digit({q[1], q[0], q_1});
      sum   = acc;
      unique case (digit)
         PM:      sum = acc + m;
         NM:      sum = acc - m;
         P2M:     sum = acc + m2;
         N2M:     sum = acc - m2;
         default: sum = acc;
      endcase
      acc_next = {{2{sum[AW-1]}}, sum[AW-1:2]};
      q_next   = {sum[1:0], q[N-1:2]};
      q_1_next = q[1];
   end
`else
   always_comb begin
      sum = acc;
      unique case ({q[0], q_1})
         2'b01:   sum = acc + m;
         2'b10:   sum = acc - m;
         default: sum = acc;
      endcase
      acc_next = {sum[AW-1], sum[AW-1:1]};
      q_next   = {sum[0], q[N-1:1]};
      q_1_next = q[0];
   end
`endif

endmodule

// File: rtl/booth.sv
// Sequential signed Booth multiplier with a start/busy/done handshake.
// BOOTH_RADIX4_EN halves the step count using radix-4 recoding.
import booth_pkg::*;

module booth #(
   parameter int unsigned N = DefaultWidth
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] mul
);

   localparam int unsigned AW    = acc_width(N);
   localparam int unsigned Steps = step_count(N);
   localparam int unsigned CW    = $clog2(N) + 1;

   if (N < 2) begin : g_width_check
      $error("booth: N must be >= 2");
   end
`ifdef BOOTH_RADIX4_EN
   if ((N % 2) != 0) begin : g_even_check
      $error("booth: N must be even for radix-4 recoding");
   end
`endif

   state_t         state_q, state_d;
   logic [AW-1:0]  acc_q, acc_d;
   logic [AW-1:0]  m_q, m_d;
   logic [N-1:0]   q_q, q_d;
   logic           q1_q, q1_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*N-1:0] mul_q, mul_d;
   logic           done_q, done_d;

   logic [AW-1:0]  acc_nx;
   logic [N-1:0]   q_nx;
   logic           q1_nx;

   booth_step #(
      .N(N)
   ) u_step (
      .acc      (acc_q),
      .q        (q_q),
      .q_1      (q1_q),
      .m        (m_q),
      .acc_next (acc_nx),
      .q_next   (q_nx),
      .q_1_next (q1_nx)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      m_d     = m_q;
      q_d     = q_q;
      q1_d    = q1_q;
      cnt_d   = cnt_q;
      mul_d   = mul_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               m_d     = {{(AW-N){a[N-1]}}, a};
               q_d     = b;
               acc_d   = '0;
               q1_d    = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = acc_nx;
            q_d   = q_nx;
            q1_d  = q1_nx;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(Steps - 1)) begin
               // Low N bits of ACC plus Q hold the full 2N-bit product.
               mul_d   = {acc_nx[N-1:0], q_nx};
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         m_q     <= '0;
         q_q     <= '0;
         q1_q    <= 1'b0;
         cnt_q   <= '0;
         mul_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         m_q     <= m_d;
         q_q     <= q_d;
         q1_q    <= q1_d;
         cnt_q   <= cnt_d;
         mul_q   <= mul_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign mul  = mul_q;

endmodule

// File: tb/tb_booth.sv
// Self-checking bench for booth: directed corners plus random pairs against a signed model.
module tb_booth;

   localparam int unsigned N = 8;
`ifdef BOOTH_RADIX4_EN
   localparam int Steps = N / 2;
`else
   localparam int Steps = N;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*N-1:0] mul;

   int             checks = 0;
   int             fails  = 0;
   logic [2*N-1:0] last_mul;
   logic [N-1:0]   corner [4];

   booth #(
      .N(N)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .mul   (mul)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [2*N-1:0] model(input logic [N-1:0] ia, input logic [N-1:0] ib);
      int sa;
      int sb;
      sa = $signed(ia);
      sb = $signed(ib);
      return (2*N)'(sa * sb);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Launch from an idle or done cycle; inject>0 raises a spurious start in that busy cycle.
   task automatic op(input logic [N-1:0] ia, input logic [N-1:0] ib, input int inject,
                     input string tag);
      logic [2*N-1:0] exp;
      exp   = model(ia, ib);
      a     = ia;
      b     = ib;
      start = 1'b1;
      step();
      start = 1'b0;
      a     = N'($urandom);
      b     = N'($urandom);
      for (int i = 1; i <= Steps; i++) begin
         if (i == inject) begin
            start = 1'b1;
            a     = N'(9);
            b     = N'(9);
         end else begin
            start = 1'b0;
         end
         check({tag, " busy"}, 64'(busy), 64'(1));
         check({tag, " done early"}, 64'(done), 64'(0));
         check({tag, " mul held"}, 64'(mul), 64'(last_mul));
         step();
      end
      start = 1'b0;
      check({tag, " done"}, 64'(done), 64'(1));
      check({tag, " busy in done"}, 64'(busy), 64'(0));
      check({tag, " product"}, 64'(mul), 64'(exp));
      last_mul = exp;
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      a         = '0;
      b         = '0;
      last_mul  = '0;
      corner[0] = 8'h80;
      corner[1] = 8'h7F;
      corner[2] = 8'h00;
      corner[3] = 8'hFF;
      #12;
      check("reset busy", 64'(busy), 64'(0));
      check("reset done", 64'(done), 64'(0));
      check("reset mul", 64'(mul), 64'(0));
      rst = 1'b0;
      step();

      op(8'd3, 8'd5, 0, "3x5");
      step();
      check("hold mul", 64'(mul), 64'(16'h000F));
      check("hold done", 64'(done), 64'(0));
      check("hold busy", 64'(busy), 64'(0));

      // Asynchronous abort after three steps.
      a     = 8'd5;
      b     = 8'd7;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      check("abort pre busy", 64'(busy), 64'(1));
      #2 rst = 1'b1;
      #1;
      check("abort busy", 64'(busy), 64'(0));
      check("abort done", 64'(done), 64'(0));
      check("abort mul", 64'(mul), 64'(0));
      #1 rst = 1'b0;
      last_mul = '0;
      step();
      for (int i = 0; i < Steps + 2; i++) begin
         check("abort no done", 64'(done), 64'(0));
         check("abort idle", 64'(busy), 64'(0));
         step();
      end

      // Back-to-back launches in the done cycle.
      op(8'h80, 8'h80, 0, "m128xm128");
      op(8'h80, 8'h7F, 0, "m128x127");
      op(8'hFF, 8'h01, 0, "m1x1");
      op(8'h00, 8'hA5, 0, "0xA5");
      step();

      op(8'h0C, 8'hF3, 2, "ignored start");
      step();
      check("ignored no relaunch", 64'(busy), 64'(0));
      check("ignored mul", 64'(mul), 64'(model(8'h0C, 8'hF3)));

      for (int k = 0; k < 100; k++) begin
         logic [N-1:0] ia;
         logic [N-1:0] ib;
         ia = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : N'($urandom);
         ib = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : N'($urandom);
         op(ia, ib, 0, "random");
         if ($urandom_range(0, 1) == 1) begin
            step();
            check("random gap done", 64'(done), 64'(0));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/booth.md
Name: booth

Overview:
- Sequential signed two's-complement multiplier using radix-2 Booth recoding.
- Multiplies an N-bit multiplicand by an N-bit multiplier and returns the exact 2N-bit signed product.
- Intended as a small, area-lean arithmetic block behind a simple start/done handshake in datapaths that can tolerate multi-cycle latency.

Parameters:
- N, 8, operand width in bits; must be >= 2; must be even when BOOTH_RADIX4_EN is defined.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled on a rising clk edge when busy=0
- a  input  N  multiplicand, signed two's complement
- b  input  N  multiplier, signed two's complement
- busy  output  1  high while an operation is in progress
- done  output  1  single-cycle pulse: mul is valid
- mul  output  2N  signed product a*b; held until the next completion or reset

Behaviour:
- Reset (async, rst=1): busy=0, done=0, mul=0, all internal registers 0, FSM=IDLE. Reset mid-operation aborts the operation; no done pulse follows.
- FSM states:
  - IDLE: on a clk edge with start=1, latch a and b, then go to RUN. This happens at edge k.
  - RUN: perform one Booth step per edge. After the final step (edge k+N), load mul, pulse done, and return to IDLE.
- Latency: busy=1 during cycles k+1 .. k+N. done=1 exactly during the cycle after edge k+N; busy=0 in that cycle.
- start while busy=1 is ignored; operands are not re-latched.
- start=1 in the done cycle is accepted; back-to-back throughput is one result per N+1 cycles.
- Datapath:
  - Accumulator ACC is N+1 bits, sign-extended.
  - Q holds the multiplier; Q_1 is a 1-bit register initialised to 0.
  - Multiplicand M is sign-extended to N+1 bits.
- Each step looks at {Q[0], Q_1}:
  - 01: ACC += M.
  - 10: ACC -= M.
  - 00 or 11: no operation.
  - Then arithmetic-shift right {ACC, Q, Q_1} by one.
- Result: mul = {ACC[N-1:0], Q} after N steps.
- Boundary cases (the N+1-bit ACC makes all of these exact, no overflow):
  - Most-negative operands are exact: -128 * -128 = 16384 (0x4000) for N=8.
  - Zero operands give 0.
  - Any operand combination yields the mathematically exact signed product; no saturation or overflow flag.
- a and b may change freely after the capture edge without affecting the result.

Optional Feature:
- Macro BOOTH_RADIX4_EN.
- When defined:
  - Radix-4 (modified Booth) recoding examines {Q[1], Q[0], Q_1} and selects one of 0, ±M, ±2M.
  - ACC widened to N+2 bits; shift by 2 per step.
  - N/2 steps, so done appears the cycle after edge k+N/2.
  - busy=1 during cycles k+1 .. k+N/2.
  - N must be even; elaborate-time error otherwise.
- When undefined: the radix-2 behaviour above.
- Products are bit-identical in both builds.

Decomposition:
- Package booth_pkg contains:
  - FSM state typedef (IDLE, RUN).
  - Default width constant (8).
  - Radix-4 digit encoding typedef (ZERO, PM, NM, P2M, N2M) used under BOOTH_RADIX4_EN.
- One natural sub-module, booth_step: purely combinational. Takes ACC, Q, Q_1 and M; returns the next ACC, Q and Q_1 (add/sub plus arithmetic shift, radix selected by macro).
- Top level holds the FSM, step counter (width clog2(N)+1), and the operand/result registers.

Test Plan:
- rst=1 mid-RUN (a=5, b=7, after 3 steps) -> busy=0, done=0, mul=0 immediately and asynchronously; no later done pulse.
- a=3, b=5, start one cycle -> busy high for 8 cycles; done pulses the next cycle with mul=0x000F; mul holds afterwards.
- a=0x80 (-128), b=0x80 -> mul=0x4000. Then a=0x80, b=0x7F -> mul=0xC080 (-16256).
- a=0xFF (-1), b=0x01 -> mul=0xFFFF. Then a=0x00, b=0xA5 -> mul=0x0000.
- start asserted again during busy with a=9, b=9 -> ignored, first result unaffected. start in the done cycle -> accepted; second done arrives N+1 cycles later.
- 100 random pairs (including the 0x80/0x7F/0x00/0xFF corners) compared against a signed reference model, run in both the radix-2 build and the BOOTH_RADIX4_EN build. In the radix-4 build, done latency = N/2+1 cycles from start.
